// File: rtl/dmem_checker_pkg.sv
// Shared types and default parameters for the data-memory completion checker.
package dmem_checker_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] DEF_DONE_ADDR      = 32'd100;
    localparam logic [31:0] DEF_EXPECT_DATA    = 32'd25;
    localparam logic [31:0] DEF_SCRATCH_ADDR   = 32'd96;
    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd1000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_checker_if.sv
// CPU data-port bus plus verdict outputs of the checker.
interface dmem_checker_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] store_count;
    logic [31:0] fail_addr;

    modport master (
        output MemWrite, DataAdr, WriteData,
        input  ReadData, done, pass, timeout, store_count, fail_addr
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData,
        output ReadData, done, pass, timeout, store_count, fail_addr
    );

endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 data RAM: synchronous write, combinational read, no reset.
module dmem_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_checker.sv
// Data memory for a test CPU that also watches stores and issues a
// pass / fail / timeout verdict from the completion store.
module dmem_checker
    import dmem_checker_pkg::*;
#(
    parameter int unsigned DEPTH          = 64,
    parameter logic [31:0] DONE_ADDR      = DEF_DONE_ADDR,
    parameter logic [31:0] EXPECT_DATA    = DEF_EXPECT_DATA,
    parameter logic [31:0] SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    dmem_checker_if.slave bus
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RANGE_LIM = 32'(4 * DEPTH);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] count_q, count_d;
    logic [31:0] fail_addr_q, fail_addr_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;

    logic        in_run, store, aligned, in_range, ram_we;
    logic [31:0] ram_rdata;

    assign in_run   = (state_q == ST_RUN);
    assign store    = bus.MemWrite && in_run;
    assign aligned  = (bus.DataAdr[1:0] == 2'b00);
    assign in_range = (bus.DataAdr < RANGE_LIM);
    // Misaligned or out-of-range stores still count and decide, but never hit the RAM.
    assign ram_we   = store && aligned && in_range;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (bus.DataAdr[AW+1:2]),
        .wdata_i (bus.WriteData),
        .rdata_o (ram_rdata)
    );

    assign bus.ReadData = in_range ? ram_rdata : 32'd0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        count_d     = count_q;
        fail_addr_d = fail_addr_q;
        if (in_run) begin
            cnt_d = cnt_q + 32'd1;
            // A store decides before the timeout when both land on the same edge.
            if (store) begin
                count_d = sat_inc16(count_q);
                if (!aligned) begin
                    state_d = ST_FAIL;
                end else if (bus.DataAdr == DONE_ADDR) begin
                    state_d = (bus.WriteData == EXPECT_DATA) ? ST_PASS : ST_FAIL;
                end else if (bus.DataAdr != SCRATCH_ADDR) begin
                    state_d = ST_FAIL;
                end
            end else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                state_d = ST_TIMEOUT;
            end
            if (state_d == ST_FAIL) begin
                fail_addr_d = bus.DataAdr;
            end
        end
        done_d    = (state_d != ST_RUN);
        pass_d    = (state_d == ST_PASS);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            count_q     <= '0;
            fail_addr_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            fail_addr_q <= fail_addr_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.store_count = count_q;
    assign bus.fail_addr   = fail_addr_q;

endmodule

// File: tb/tb_dmem_checker.sv
// Directed bench for dmem_checker with a 16-cycle timeout.
module tb_dmem_checker;

    logic clk = 1'b0;
    logic reset;
    int   n_err = 0;
    int   n_chk = 0;

    dmem_checker_if bus ();

    dmem_checker #(
        .DEPTH          (64),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = addr;
        bus.WriteData = data;
        step();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic read(input logic [31:0] addr);
        bus.DataAdr = addr;
        #1;
    endtask

    // Pulse reset and release it 3 ns before the next rising edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'd0;
        bus.WriteData = 32'd0;

        #10;
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_pass",  32'(bus.pass), 32'd0);
        chk("rst_tmo",   32'(bus.timeout), 32'd0);
        chk("rst_count", 32'(bus.store_count), 32'd0);
        chk("rst_faddr", bus.fail_addr, 32'd0);
        #12;
        reset = 1'b0;

        // scratch store then passing completion store
        store(32'd96, 32'd7);
        chk("scr_done",  32'(bus.done), 32'd0);
        chk("scr_count", 32'(bus.store_count), 32'd1);
        store(32'd100, 32'd25);
        chk("p_done",  32'(bus.done), 32'd1);
        chk("p_pass",  32'(bus.pass), 32'd1);
        chk("p_tmo",   32'(bus.timeout), 32'd0);
        chk("p_count", 32'(bus.store_count), 32'd2);
        read(32'd100);
        chk("p_ram25", bus.ReadData, 32'd25);
        read(32'd96);
        chk("p_ram24", bus.ReadData, 32'd7);
        store(32'd100, 32'd24);
        chk("p_sticky_pass",  32'(bus.pass), 32'd1);
        chk("p_sticky_count", 32'(bus.store_count), 32'd2);

        // asynchronous reset from PASS, no clock edge
        reset = 1'b1;
        #1;
        chk("ar_done",  32'(bus.done), 32'd0);
        chk("ar_pass",  32'(bus.pass), 32'd0);
        chk("ar_count", 32'(bus.store_count), 32'd0);
        read(32'd96);
        chk("ar_ram24", bus.ReadData, 32'd7);
        @(negedge clk);
        #2;
        reset = 1'b0;

        // wrong completion data
        store(32'd100, 32'd24);
        chk("f_done",  32'(bus.done), 32'd1);
        chk("f_pass",  32'(bus.pass), 32'd0);
        chk("f_faddr", bus.fail_addr, 32'd100);
        chk("f_count", 32'(bus.store_count), 32'd1);
        store(32'd100, 32'd25);
        chk("f_sticky_pass",  32'(bus.pass), 32'd0);
        chk("f_sticky_count", 32'(bus.store_count), 32'd1);

        // stray store address
        do_reset();
        store(32'd40, 32'd5);
        chk("s_done",  32'(bus.done), 32'd1);
        chk("s_pass",  32'(bus.pass), 32'd0);
        chk("s_faddr", bus.fail_addr, 32'd40);

        // misaligned store must fail and leave RAM alone
        do_reset();
        store(32'd98, 32'h1234_5678);
        chk("m_done",  32'(bus.done), 32'd1);
        chk("m_faddr", bus.fail_addr, 32'd98);
        read(32'd96);
        chk("m_ram24", bus.ReadData, 32'd7);

        // load path
        do_reset();
        store(32'd96, 32'hDEAD_BEEF);
        read(32'd96);
        chk("rd_96",   bus.ReadData, 32'hDEAD_BEEF);
        chk("rd_done", 32'(bus.done), 32'd0);
        read(32'd4096);
        chk("rd_oor",  bus.ReadData, 32'd0);
        bus.DataAdr = 32'd0;

        // timeout lands on the 16th edge after release
        do_reset();
        for (int i = 0; i < 15; i++) step();
        chk("t_before", 32'(bus.timeout), 32'd0);
        chk("t_before_done", 32'(bus.done), 32'd0);
        step();
        chk("t_tmo",  32'(bus.timeout), 32'd1);
        chk("t_done", 32'(bus.done), 32'd1);
        chk("t_pass", 32'(bus.pass), 32'd0);
        store(32'd100, 32'd25);
        chk("t_sticky_pass",  32'(bus.pass), 32'd0);
        chk("t_sticky_count", 32'(bus.store_count), 32'd0);

        // passing store on the timeout edge wins
        do_reset();
        for (int i = 0; i < 15; i++) step();
        store(32'd100, 32'd25);
        chk("tie_pass",  32'(bus.pass), 32'd1);
        chk("tie_tmo",   32'(bus.timeout), 32'd0);
        chk("tie_count", 32'(bus.store_count), 32'd1);
        step();
        step();
        chk("tie_hold_tmo", 32'(bus.timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
